// File: rtl/lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lu_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one registered AND/OR
//            logic unit among N requesters. A grant latches the winner's
//            operands, the result is computed one cycle later and a
//            one-cycle done pulse marks it valid.
// Ports    : clk, rst_n (async, active-low)
//            req[N]        level-sensitive request lines
//            a_in/b_in     N packed W-bit operands, requester k at [k*W +: W]
//            chave_in[N]   per-requester select, 1 = AND, 0 = OR
//            grant[N]      registered one-hot grant
//            s_out[W]      registered result of the last transaction
//            done          one-cycle completion pulse
//            busy          high whenever the FSM is not idle
//            ops_served    16-bit wrapping completed-transaction count
// Revision : 1.0 - initial release
// ============================================================================
module lu_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  input  logic [N-1:0]   chave_in,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   s_out,
  output logic           done,
  output logic           busy,
  output logic [15:0]    ops_served
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_exec = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_idx;
  logic [N-1:0]  r_grant;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_chave;
  logic [W-1:0]  r_s;
  logic [15:0]   r_cnt;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic           w_found;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;
  logic [PW-1:0]  w_sel;
  logic [N-1:0]   w_onehot;
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic           w_chave;

  // Rotate requests so that bit 0 corresponds to requester ptr; the lowest
  // set bit of the rotated vector is then the round-robin winner.
  assign w_dbl = {req, req};
  assign w_rot = N'(w_dbl >> r_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = PW'(i);
      end
    end
  end

  // Undo the rotation: winner index = (ptr + offset) mod N.
  assign w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel    = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : w_sum[PW-1:0];
  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;

  always_comb begin
    w_a     = '0;
    w_b     = '0;
    w_chave = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_sel == PW'(i)) begin
        w_a     = a_in[i*W +: W];
        w_b     = b_in[i*W +: W];
        w_chave = chave_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_chave <= 1'b0;
      r_s     <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_found) begin
            r_grant <= w_onehot;
            r_idx   <= w_sel;
            r_a     <= w_a;
            r_b     <= w_b;
            r_chave <= w_chave;
            r_state <= c_exec;
          end
        end
        c_exec: begin
          r_s     <= r_chave ? (r_a & r_b) : (r_a | r_b);
          r_state <= c_done;
        end
        c_done: begin
          // The requester just served drops to lowest priority.
          r_grant <= '0;
          r_ptr   <= (r_idx == PW'(N - 1)) ? '0 : r_idx + PW'(1);
          r_cnt   <= r_cnt + 16'd1;
          r_state <= c_idle;
        end
        default: begin
          r_grant <= '0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Outputs are decodes of registers only, never of req.
  assign grant      = r_grant;
  assign s_out      = r_s;
  assign done       = (r_state == c_done);
  assign busy       = (r_state != c_idle);
  assign ops_served = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_arbiter
// Purpose  : Self-checking bench for lu_arbiter (N=4, W=8). Table of single
//            transactions plus hand-written round-robin, persistent-requester
//            and mid-transaction reset sequences. Expected results are pushed
//            to a queue at grant time and popped when done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   chave_in;
  logic [N-1:0]   grant;
  logic [W-1:0]   s_out;
  logic           done;
  logic           busy;
  logic [15:0]    ops_served;

  lu_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .chave_in   (chave_in),
    .grant      (grant),
    .s_out      (s_out),
    .done       (done),
    .busy       (busy),
    .ops_served (ops_served)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ch;
    logic [N-1:0] gnt;
    logic [W-1:0] s;
  } vec_t;

  vec_t         vecs[6];
  logic [W-1:0] sb_q[$];
  int           n_checks;
  int           n_pass;
  int           exp_ops;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic sb_check(input string nm);
    logic [W-1:0] e;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(nm, 32'(s_out), 32'(e));
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] g);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (g[i]) k = i;
    return k;
  endfunction

  task automatic scramble();
    a_in     = {$urandom, $urandom};
    b_in     = {$urandom, $urandom};
    chave_in = N'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    exp_ops = 0;
    sb_q.delete();
  endtask

  // Waits (bounded) for a grant rising from all-zero; returns the grant seen.
  task automatic wait_grant(input string nm, output logic [N-1:0] g);
    logic [N-1:0] prev;
    bit           hit;
    prev = grant;
    hit  = 0;
    g    = '0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (grant != 0 && prev == 0) begin
        hit = 1;
        g   = grant;
      end
      prev = grant;
    end
    if (!hit) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int v);
    int k;
    scramble();
    k = onehot_idx(vecs[v].gnt);
    a_in[k*W +: W] = vecs[v].a;
    b_in[k*W +: W] = vecs[v].b;
    chave_in[k]    = vecs[v].ch;
    req            = vecs[v].rq;
    tick(); // e1
    chk($sformatf("v%0d_grant", v), 32'(grant), 32'(vecs[v].gnt));
    chk($sformatf("v%0d_busy_e1", v), 32'(busy), 32'd1);
    chk($sformatf("v%0d_done_e1", v), 32'(done), 32'd0);
    sb_q.push_back(vecs[v].s);
    req = '0;
    scramble(); // operands after the grant edge must not matter
    tick(); // e2
    chk($sformatf("v%0d_done_e2", v), 32'(done), 32'd1);
    chk($sformatf("v%0d_grant_e2", v), 32'(grant), 32'(vecs[v].gnt));
    sb_check($sformatf("v%0d_s_out", v));
    tick(); // e3
    exp_ops++;
    chk($sformatf("v%0d_grant_e3", v), 32'(grant), 32'd0);
    chk($sformatf("v%0d_busy_e3", v), 32'(busy), 32'd0);
    chk($sformatf("v%0d_done_e3", v), 32'(done), 32'd0);
    chk($sformatf("v%0d_ops", v), 32'(ops_served), 32'(exp_ops));
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] rr_g[5];
    int           rr_c[5];
    int           ng;
    int           nd;
    int           k;
    logic [N-1:0] prev;

    n_checks = 0;
    n_pass   = 0;
    exp_ops  = 0;

    // ptr sequence: 0 -> 1 -> 3 -> 1 -> 0 -> 1 -> 3
    vecs[0] = '{rq: 4'b0001, a: 8'hF0, b: 8'h3C, ch: 1'b1, gnt: 4'b0001, s: 8'h30};
    vecs[1] = '{rq: 4'b0100, a: 8'hF0, b: 8'h3C, ch: 1'b0, gnt: 4'b0100, s: 8'hFC};
    vecs[2] = '{rq: 4'b0011, a: 8'hAA, b: 8'h55, ch: 1'b0, gnt: 4'b0001, s: 8'hFF};
    vecs[3] = '{rq: 4'b1001, a: 8'hAA, b: 8'h0F, ch: 1'b1, gnt: 4'b1000, s: 8'h0A};
    vecs[4] = '{rq: 4'b1111, a: 8'h12, b: 8'h34, ch: 1'b0, gnt: 4'b0001, s: 8'h36};
    vecs[5] = '{rq: 4'b1100, a: 8'hFF, b: 8'h81, ch: 1'b1, gnt: 4'b0100, s: 8'h81};

    // Reset with random inputs
    rst_n = 1'b0;
    req   = N'($urandom);
    scramble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_s_out", 32'(s_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops", 32'(ops_served), 32'd0);
    req   = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("idle%0d_busy", c), 32'(busy), 32'd0);
      chk($sformatf("idle%0d_grant", c), 32'(grant), 32'd0);
    end

    // Table-driven single transactions
    for (int v = 0; v < 6; v++) run_vec(v);

    // Round-robin with all requests held from reset
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 8'(8'h11 * (i + 1));
      b_in[i*W +: W] = 8'hFF;
      chave_in[i]    = 1'b1;
    end
    req = 4'b1111;
    apply_reset();
    ng   = 0;
    nd   = 0;
    prev = grant;
    for (int c = 0; c < 40 && nd < 5; c++) begin
      tick();
      if (grant != 0 && prev == 0 && ng < 5) begin
        rr_g[ng] = grant;
        rr_c[ng] = c;
        ng++;
        k = onehot_idx(grant);
        sb_q.push_back(a_in[k*W +: W]);
      end
      if (done) begin
        sb_check($sformatf("rr_s_out%0d", nd));
        nd++;
      end
      prev = grant;
    end
    chk("rr_done_count", 32'(nd), 32'd5);
    tick();
    chk("rr_ops", 32'(ops_served), 32'd5);
    req = '0;
    if (ng == 5) begin
      chk("rr_g0", 32'(rr_g[0]), 32'b0001);
      chk("rr_g1", 32'(rr_g[1]), 32'b0010);
      chk("rr_g2", 32'(rr_g[2]), 32'b0100);
      chk("rr_g3", 32'(rr_g[3]), 32'b1000);
      chk("rr_g4", 32'(rr_g[4]), 32'b0001);
      for (int i = 1; i < 5; i++)
        chk($sformatf("rr_gap%0d", i), 32'(rr_c[i] - rr_c[i-1]), 32'd3);
    end else begin
      chk("rr_grant_count", 32'(ng), 32'd5);
    end

    // Persistent requester 1, requester 3 pulses after 1 is granted
    for (int i = 0; i < N; i++) begin
      a_in[i*W +: W] = 8'h5A;
      b_in[i*W +: W] = 8'h0F;
      chave_in[i]    = 1'b0;
    end
    req = 4'b0010;
    apply_reset();
    wait_grant("pers_first", g);
    chk("pers_first", 32'(g), 32'b0010);
    req = 4'b1010;
    wait_grant("pers_second", g);
    chk("pers_second", 32'(g), 32'b1000);
    req = 4'b0010;
    wait_grant("pers_third", g);
    chk("pers_third", 32'(g), 32'b0010);
    req = '0;
    tick();
    chk("pers_done", 32'(done), 32'd1);
    chk("pers_s_out", 32'(s_out), 32'h5F);
    tick();
    chk("pers_ops", 32'(ops_served), 32'd3);

    // Reset during EXEC; ptr is 2 here, so 0110 grants requester 2 first
    req = 4'b0110;
    tick();
    chk("mid_grant_pre", 32'(grant), 32'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_grant_rst", 32'(grant), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_s_out_rst", 32'(s_out), 32'd0);
    chk("mid_done_rst", 32'(done), 32'd0);
    chk("mid_ops_rst", 32'(ops_served), 32'd0);
    #3 rst_n = 1'b1;
    wait_grant("mid_regrant", g);
    chk("mid_regrant", 32'(g), 32'b0010);
    chk("mid_regrant_done", 32'(done), 32'd0);
    req = '0;
    tick();
    chk("mid_done_e2", 32'(done), 32'd1);
    chk("mid_s_out_e2", 32'(s_out), 32'h5F);
    tick();
    chk("mid_ops_e3", 32'(ops_served), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
